// File: rtl/dispense_scheduler.sv
// Shares one dispense motor between the candy and soda requesters.
// Each grant runs motor drive, then waits for the product sensor.
// An unconfirmed attempt is retried; when retries run out the block faults.
module dispense_scheduler #(
  parameter int unsigned DRIVE_TICKS = 5,
  parameter int unsigned SENSE_TICKS = 20,
  parameter int unsigned RETRIES     = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic [1:0] req_i,
  input  logic       sensor_i,
  input  logic       clr_fault_i,
  output logic       motor_en_o,
  output logic       motor_sel_o,
  output logic [1:0] ack_o,
  output logic [1:0] err_o,
  output logic       busy_o,
  output logic       fault_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_GRANT, S_DRIVE, S_SENSE, S_DONE, S_RELEASE, S_FAULT
  } state_e;

  // Tick counters compare against N-1 because the count starts at zero.
  localparam logic [7:0] DRIVE_LAST = 8'(DRIVE_TICKS - 1);
  localparam logic [7:0] SENSE_LAST = 8'(SENSE_TICKS - 1);
  localparam logic [1:0] RETRY_MAX  = 2'(RETRIES);

  state_e     state_q, state_d;
  logic       sel_q, sel_d;         // requester being served: 0 candy, 1 soda
  logic       last_q, last_d;       // last requester served; breaks ties
  logic       seen_q, seen_d;       // sensor edge seen while driving
  logic [7:0] tick_cnt_q, tick_cnt_d;
  logic [1:0] att_q, att_d;
  logic [1:0] err_q, err_d;
  logic       sync1_q, sync2_q, sync3_q;
  logic       sensor_ev;

  // Two-flop synchronizer for the raw sensor, plus one delay stage for edge detection.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
    end else begin
      sync1_q <= sensor_i;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
    end
  end

  assign sensor_ev = sync2_q & ~sync3_q;

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      seen_q     <= 1'b0;
      tick_cnt_q <= 8'd0;
      att_q      <= 2'd0;
      err_q      <= 2'b00;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      seen_q     <= seen_d;
      tick_cnt_q <= tick_cnt_d;
      att_q      <= att_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: arbitration, drive/sense timing, retry and fault handling.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    seen_d     = seen_q;
    tick_cnt_d = tick_cnt_q;
    att_d      = att_q;
    err_d      = 2'b00;
    unique case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          state_d = S_GRANT;
          // On a tie the requester not served last goes first.
          sel_d   = (req_i == 2'b11) ? ~last_q : req_i[1];
        end
      end
      S_GRANT: begin
        tick_cnt_d = 8'd0;
        att_d      = 2'd0;
        seen_d     = 1'b0;
        state_d    = S_DRIVE;
      end
      S_DRIVE: begin
        if (sensor_ev) seen_d = 1'b1;
        if (tick_i) begin
          if (tick_cnt_q == DRIVE_LAST) begin
            tick_cnt_d = 8'd0;
            state_d    = S_SENSE;
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      S_SENSE: begin
        // The sensor is checked first so it wins over a coinciding timeout tick.
        if (seen_q || sensor_ev) begin
          state_d = S_DONE;
        end else if (tick_i) begin
          if (tick_cnt_q == SENSE_LAST) begin
            tick_cnt_d = 8'd0;
            if (att_q < RETRY_MAX) begin
              att_d   = att_q + 2'd1;
              state_d = S_DRIVE;
            end else begin
              err_d[sel_q] = 1'b1;
              last_d       = sel_q;
              state_d      = S_FAULT;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 8'd1;
          end
        end
      end
      S_DONE: begin
        last_d  = sel_q;
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        // A held request must drop before it can be served again.
        if (!req_i[sel_q]) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (clr_fault_i) state_d = S_RELEASE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign motor_en_o  = (state_q == S_DRIVE);
  assign motor_sel_o = sel_q;
  assign ack_o       = (state_q == S_DONE) ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
  assign err_o       = err_q;
  assign busy_o      = (state_q != S_IDLE);
  assign fault_o     = (state_q == S_FAULT);

endmodule

// File: tb/tb_dispense_scheduler.sv
// Randomized bench for dispense_scheduler with a transaction-level reference model.
module tb_dispense_scheduler;

  localparam int DRIVE_TICKS = 5;
  localparam int SENSE_TICKS = 20;
  localparam int RETRIES     = 1;
  localparam int RAND_CYCLES = 6000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick;
  logic [1:0] req;
  logic       sensor;
  logic       clr_fault;
  logic       motor_en;
  logic       motor_sel;
  logic [1:0] ack;
  logic [1:0] err;
  logic       busy;
  logic       fault;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Expected outputs produced by the reference model.
  logic       m_motor_en = 1'b0;
  logic       m_sel      = 1'b0;
  logic [1:0] m_ack      = 2'b00;
  logic [1:0] m_err      = 2'b00;
  logic       m_busy     = 1'b0;
  logic       m_fault    = 1'b0;

  // Model's view of the inputs at each rising edge.
  logic [1:0] s_req;
  logic       s_tick, s_clr, s_ev;
  logic       h0 = 1'b0, h1 = 1'b0, h2 = 1'b0;

  dispense_scheduler #(
    .DRIVE_TICKS(DRIVE_TICKS),
    .SENSE_TICKS(SENSE_TICKS),
    .RETRIES    (RETRIES)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .tick_i     (tick),
    .req_i      (req),
    .sensor_i   (sensor),
    .clr_fault_i(clr_fault),
    .motor_en_o (motor_en),
    .motor_sel_o(motor_sel),
    .ack_o      (ack),
    .err_o      (err),
    .busy_o     (busy),
    .fault_o    (fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock of the model: sample inputs; a sensor event is a rising edge
  // on the raw sensor seen two samples earlier (synchronizer delay).
  task automatic step();
    @(posedge clk);
    s_req  = req;
    s_tick = tick;
    s_clr  = clr_fault;
    s_ev   = h1 & ~h2;
    h2 = h1;
    h1 = h0;
    h0 = sensor;
  endtask

  // Reference model: one pass of the loop is one complete grant.
  initial begin : model
    logic sel_m;
    logic last_m;
    int   ticks;
    int   att;
    bit   seen, fin, ok, sense_end;
    last_m = 1'b1;
    ok     = 1'b0;
    @(posedge rst_n);
    forever begin
      do step(); while (s_req == 2'b00);
      sel_m  = (s_req == 2'b11) ? ~last_m : s_req[1];
      m_busy = 1'b1;
      m_sel  = sel_m;
      step();                      // grant cycle: ticks and sensor ignored
      seen = 1'b0;
      att  = 0;
      fin  = 1'b0;
      while (!fin) begin
        m_motor_en = 1'b1;
        ticks = 0;
        while (ticks < DRIVE_TICKS) begin
          step();
          if (s_ev) seen = 1'b1;
          if (s_tick) ticks++;
        end
        m_motor_en = 1'b0;
        ticks = 0;
        sense_end = 1'b0;
        while (!sense_end) begin
          step();
          if (seen || s_ev) begin
            sense_end = 1'b1;
            fin = 1'b1;
            ok  = 1'b1;
          end else if (s_tick) begin
            ticks++;
            if (ticks == SENSE_TICKS) begin
              sense_end = 1'b1;
              if (att < RETRIES) att++;
              else begin
                fin = 1'b1;
                ok  = 1'b0;
              end
            end
          end
        end
      end
      last_m = sel_m;
      if (ok) begin
        m_ack[sel_m] = 1'b1;
        step();
        m_ack = 2'b00;
      end else begin
        m_err[sel_m] = 1'b1;
        m_fault = 1'b1;
        step();
        m_err = 2'b00;
        while (!s_clr) step();
        m_fault = 1'b0;
      end
      do step(); while (s_req[sel_m]);
      m_busy = 1'b0;
    end
  end

  // Compare every output against the model once per cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("motor_en", 32'(motor_en), 32'(m_motor_en));
      check_eq("ack",      32'(ack),      32'(m_ack));
      check_eq("err",      32'(err),      32'(m_err));
      check_eq("busy",     32'(busy),     32'(m_busy));
      check_eq("fault",    32'(fault),    32'(m_fault));
      if (m_busy) check_eq("motor_sel", 32'(motor_sel), 32'(m_sel));
    end
  end

  initial begin : stim
    int rq_st[2];
    int rq_cnt[2];
    int sen_mode;
    int sen_cnt;
    int k;
    rst_n = 1'b0; tick = 1'b0; req = 2'b00; sensor = 1'b0; clr_fault = 1'b0;
    sen_mode = 1; sen_cnt = 0;
    for (int i = 0; i < 2; i++) begin
      rq_st[i]  = 0;
      rq_cnt[i] = $urandom_range(0, 3);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_motor_en",  32'(motor_en),  0);
    check_eq("rst_motor_sel", 32'(motor_sel), 0);
    check_eq("rst_ack",       32'(ack),       0);
    check_eq("rst_err",       32'(err),       0);
    check_eq("rst_busy",      32'(busy),      0);
    check_eq("rst_fault",     32'(fault),     0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Random traffic; sensor activity varies by segment so that quick
    // confirms, retries and faults all occur.
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc % 500 == 0) sen_mode = $urandom_range(0, 2);
      tick      = ($urandom_range(0, 2) == 0);
      clr_fault = ($urandom_range(0, 39) == 0);
      if (sen_cnt > 0) begin
        sen_cnt--;
        if (sen_cnt == 0) sensor = 1'b0;
      end else if ((sen_mode == 1 && $urandom_range(0, 14) == 0) ||
                   (sen_mode == 2 && $urandom_range(0, 79) == 0)) begin
        sensor  = 1'b1;
        sen_cnt = $urandom_range(1, 4);
      end
      for (int i = 0; i < 2; i++) begin
        case (rq_st[i])
          0: begin
            if (rq_cnt[i] == 0) begin
              req[i]   = 1'b1;
              rq_st[i] = 1;
            end else rq_cnt[i]--;
          end
          1: begin
            if (ack[i] || err[i]) begin
              rq_st[i]  = 2;
              rq_cnt[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 40) : $urandom_range(0, 2);
            end
          end
          default: begin
            if (rq_cnt[i] == 0) begin
              req[i]    = 1'b0;
              rq_st[i]  = 0;
              rq_cnt[i] = $urandom_range(0, 25);
            end else rq_cnt[i]--;
          end
        endcase
      end
    end

    // Drain to idle: requests dropped, sensor busy, faults cleared.
    req = 2'b00;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      tick      = ($urandom_range(0, 2) == 0);
      sensor    = 1'($urandom_range(0, 1));
      clr_fault = ($urandom_range(0, 9) == 0);
      k++;
    end while (busy && k < 2000);
    check_eq("drain_idle", 32'(busy), 0);

    // Request-to-motor latency from idle.
    tick = 1'b0; sensor = 1'b0; clr_fault = 1'b0;
    @(posedge clk);
    #1;
    req = 2'b01;
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!motor_en && k < 10);
    check_eq("req_to_motor_latency", k, 2);

    // Asynchronous reset mid-drive must drop the motor at once.
    #2;
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_eq("async_rst_motor_en", 32'(motor_en), 0);
    check_eq("async_rst_busy",     32'(busy),     0);
    check_eq("async_rst_motor_sel",32'(motor_sel),0);
    repeat (2) @(posedge clk);
    #1;
    req   = 2'b11;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("post_rst_grant_busy",  32'(busy),      1);
    check_eq("post_rst_grant_motor", 32'(motor_en),  0);
    check_eq("post_rst_grant_sel",   32'(motor_sel), 0);
    @(negedge clk);
    check_eq("post_rst_drive_motor", 32'(motor_en),  1);
    check_eq("post_rst_drive_sel",   32'(motor_sel), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
